// File: rtl/sync_fifo_v2_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode constants and
// a width helper that also covers the degenerate single-bit case.
package sync_fifo_v2_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifoWidth(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH storage array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, programmable almost flags, occupancy count, flush and error pulses.
module sync_fifo_v2
  import sync_fifo_v2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            wr_en,
  input  logic [DATA_WIDTH-1:0]           data_i,
  input  logic                            rd_en,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [fifoWidth(DEPTH+1)-1:0]   count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int CW = fifoWidth(DEPTH + 1);
  localparam int AW = fifoWidth(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_v2: DEPTH must be >= 2");
  end
  if (AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_v2: AFULL_TH must be <= DEPTH");
  end
  if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
    $error("sync_fifo_v2: AEMPTY_TH must be < DEPTH");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A flush in the same cycle wins over any request, so it masks both accepts.
  assign wr_acc = wr_en & ~full & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap compare: DEPTH need not be a power of two.
      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en & full & ~clr;
      underflow_q <= rd_en & empty & ~clr;
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_regfile (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign data_o = rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Output register only moves on an accepted read; flush leaves it alone.
    always_comb begin
      data_d = data_q;
      if (rd_acc) begin
        data_d = rdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign data_o = data_q;
  end

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Scoreboard bench: a DEPTH=5 standard-mode FIFO driven against a reference
// queue model, plus a DEPTH=4 FWFT instance exercising fall-through reads.
module tb_sync_fifo_v2;

  localparam int DEPTH_A = 5;
  localparam int DEPTH_B = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  logic       aClr, aWr, aRd;
  logic [7:0] aDin, aDout;
  logic       aFull, aEmpty, aAfull, aAempty, aOvf, aUdf;
  logic [2:0] aCount;

  logic       bClr, bWr, bRd;
  logic [7:0] bDin, bDout;
  logic       bFull, bEmpty, bAfull, bAempty, bOvf, bUdf;
  logic [2:0] bCount;

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH_A), .FWFT(0)) dutA (
    .clk(clk), .rst_n(rst_n), .clr(aClr), .wr_en(aWr), .data_i(aDin),
    .rd_en(aRd), .data_o(aDout), .full(aFull), .empty(aEmpty),
    .almost_full(aAfull), .almost_empty(aAempty), .count(aCount),
    .overflow(aOvf), .underflow(aUdf)
  );

  sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(DEPTH_B), .FWFT(1)) dutB (
    .clk(clk), .rst_n(rst_n), .clr(bClr), .wr_en(bWr), .data_i(bDin),
    .rd_en(bRd), .data_o(bDout), .full(bFull), .empty(bEmpty),
    .almost_full(bAfull), .almost_empty(bAempty), .count(bCount),
    .overflow(bOvf), .underflow(bUdf)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] expQ[$];
  int         mCount   = 0;
  logic [7:0] lastData = 8'h00;
  logic [7:0] bQ[$];
  int         maxCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle on dutA; the model decides acceptance from pre-edge occupancy.
  task automatic applyStimulus(input logic wr, input logic [7:0] din, input logic rd, input logic clrIn);
    logic wAcc, rAcc, expOvf, expUdf;
    wAcc   = wr && (mCount < DEPTH_A) && !clrIn;
    rAcc   = rd && (mCount > 0) && !clrIn;
    expOvf = wr && (mCount == DEPTH_A) && !clrIn;
    expUdf = rd && (mCount == 0) && !clrIn;
    aWr = wr; aDin = din; aRd = rd; aClr = clrIn;
    if (rAcc) lastData = expQ.pop_front();
    if (wAcc) expQ.push_back(din);
    if (clrIn) begin
      expQ.delete();
      mCount = 0;
    end else begin
      mCount = mCount + (wAcc ? 1 : 0) - (rAcc ? 1 : 0);
    end
    if (mCount > maxCount) maxCount = mCount;
    @(posedge clk);
    #1;
    aWr = 1'b0; aRd = 1'b0; aClr = 1'b0; aDin = 8'h00;
    checkOutput("countA", aCount, mCount);
    checkOutput("dataA", aDout, lastData);
    checkOutput("overflowA", aOvf, expOvf);
    checkOutput("underflowA", aUdf, expUdf);
    checkOutput("fullA", aFull, mCount == DEPTH_A);
    checkOutput("emptyA", aEmpty, mCount == 0);
    checkOutput("almostFullA", aAfull, mCount >= DEPTH_A - 2);
    checkOutput("almostEmptyA", aAempty, mCount <= 2);
  endtask

  task automatic stepB(input logic wr, input logic [7:0] din, input logic rd);
    bWr = wr; bDin = din; bRd = rd;
    @(posedge clk);
    #1;
    bWr = 1'b0; bRd = 1'b0; bDin = 8'h00;
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0;
    aClr = 0; aWr = 0; aRd = 0; aDin = 0;
    bClr = 0; bWr = 0; bRd = 0; bDin = 0;
    #12;
    checkOutput("rstCount", aCount, 0);
    checkOutput("rstEmpty", aEmpty, 1);
    checkOutput("rstFull", aFull, 0);
    checkOutput("rstAempty", aAempty, 1);
    checkOutput("rstAfull", aAfull, 0);
    checkOutput("rstData", aDout, 0);
    checkOutput("rstOvf", aOvf, 0);
    checkOutput("rstUdf", aUdf, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] fill, overflow and drain");
    for (int i = 1; i <= 5; i++) applyStimulus(1, 8'(i * 8'h11), 0, 0);
    applyStimulus(1, 8'h66, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 8'h00, 1, 0);

    $display("[TB] pointer wrap");
    pat = 8'h80;
    maxCount = 0;
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1, pat, 0, 0);
        pat++;
      end
      for (int k = 0; k < 3; k++) applyStimulus(0, 8'h00, 1, 0);
    end
    checkOutput("wrapMaxCount", maxCount, 3);

    $display("[TB] simultaneous read and write");
    applyStimulus(1, 8'hC1, 0, 0);
    applyStimulus(1, 8'hC2, 0, 0);
    applyStimulus(1, 8'hC3, 1, 0);
    applyStimulus(1, 8'hC4, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'hD0, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'hE0 + i), 0, 0);
    applyStimulus(1, 8'hEE, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0);

    $display("[TB] flush");
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h31 + i), 0, 0);
    applyStimulus(1, 8'h3F, 0, 1);
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'h41, 0, 0);
    applyStimulus(0, 8'h00, 1, 0);

    $display("[TB] asynchronous reset mid-cycle");
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'h51 + i), 0, 0);
    applyStimulus(0, 8'h00, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncCount", aCount, 0);
    checkOutput("asyncEmpty", aEmpty, 1);
    checkOutput("asyncData", aDout, 0);
    checkOutput("asyncFull", aFull, 0);
    expQ.delete();
    mCount = 0;
    lastData = 8'h00;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 8'h00, 1, 0);
    applyStimulus(1, 8'h77, 0, 0);

    $display("[TB] FWFT instance");
    stepB(1, 8'hA5, 0);
    checkOutput("fwftEmpty", bEmpty, 0);
    checkOutput("fwftData", bDout, 8'hA5);
    checkOutput("fwftCount", bCount, 1);
    stepB(0, 8'h00, 1);
    checkOutput("fwftEmptyAfterPop", bEmpty, 1);
    checkOutput("fwftCountAfterPop", bCount, 0);
    for (int i = 0; i < 4; i++) begin
      stepB(1, 8'(8'h61 + i), 0);
      bQ.push_back(8'(8'h61 + i));
    end
    checkOutput("fwftFull", bFull, 1);
    stepB(1, 8'h6F, 0);
    checkOutput("fwftOverflow", bOvf, 1);
    while (bQ.size() > 0) begin
      checkOutput("fwftHead", bDout, bQ.pop_front());
      stepB(0, 8'h00, 1);
    end
    checkOutput("fwftDrained", bEmpty, 1);
    stepB(0, 8'h00, 1);
    checkOutput("fwftUnderflow", bUdf, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
